instr_load_sequencer: RTL and testbench

//  Transmit side of the CPU instruction-load port. A host pushes program words into
//  an internal buffer; on start the block streams them into the CPU one word per clock

---
 rtl/instr_load_sequencer_pkg.sv | 26 ++
 rtl/instr_load_sequencer_buffer.sv | 39 +++
 rtl/instr_load_sequencer.sv | 134 +++++++++++++
 tb/tb_instr_load_sequencer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_load_sequencer_pkg.sv
// Shared definitions for the CPU instruction-load port: sequencer state encoding,
// default word width and MIPS-style opcode/funct constants used when building programs.
package cpu_load_defs;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      CPURST = 3'd2,
      RUN    = 3'd3,
      DONE   = 3'd4
   } state_t;

   localparam int WIDTH_DEFAULT = 32;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [5:0] FUNCT_ADD = 6'b100000;
   localparam logic [5:0] FUNCT_SUB = 6'b100010;
   localparam logic [5:0] FUNCT_AND = 6'b100100;
   localparam logic [5:0] FUNCT_OR  = 6'b100101;
   localparam logic [5:0] FUNCT_SLT = 6'b101010;

endpackage

// File: rtl/instr_load_sequencer_buffer.sv
// Program buffer: words are appended in write order at index count, read back
// combinationally by index. The caller only asserts wr_en when there is room.
module instr_buffer #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 32
) (
   input  logic                     clk,
   input  logic                     Reset,
   input  logic                     clear,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic [$clog2(DEPTH)-1:0] rd_idx,
   output logic [WIDTH-1:0]         rd_data,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (Reset || clear) begin
         count <= '0;
      end else if (wr_en) begin
         count <= count + CW'(1);
      end
   end

   // Contents are not cleared on reset; count alone defines what is valid.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[count[AW-1:0]] <= wr_data;
      end
   end

   assign rd_data = mem[rd_idx];

endmodule

// File: rtl/instr_load_sequencer.sv
// Streams a buffered program into the CPU one word per clock, pulses the CPU reset
// for one cycle, then counts a fixed run budget and raises done.
module instr_load_sequencer
   import cpu_load_defs::*;
#(
   parameter int DEPTH      = 16,
   parameter int WIDTH      = WIDTH_DEFAULT,
   parameter int RUN_CYCLES = 10
) (
   input  logic                   clk,
   input  logic                   Reset,
   input  logic                   wr_valid,
   input  logic [WIDTH-1:0]       wr_data,
   output logic                   wr_ready,
   input  logic                   start,
   input  logic                   clear,
   output logic                   LoadInstructions,
   output logic [WIDTH-1:0]       Instruction,
   output logic                   cpu_reset,
   output logic                   busy,
   output logic                   done,
   output logic [$clog2(DEPTH):0] count,
   output logic [2:0]             dbg_state
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int RW = $clog2(RUN_CYCLES + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   state_t          state;
   logic [CW-1:0]   idx;
   logic [RW-1:0]   run_cnt;
   logic            idle_like;
   logic            wr_fire;
   logic            start_ok;
   logic [CW-1:0]   count_next;
   logic [AW-1:0]   rd_idx;
   logic [WIDTH-1:0] rd_data;

   // Handshake: a word transfers on any rising edge where wr_valid && wr_ready;
   // wr_ready is registered and only ever high in IDLE/DONE with room in the buffer.
   always_comb begin
      idle_like  = (state == IDLE) || (state == DONE);
      wr_fire    = idle_like && !clear && wr_valid && wr_ready;
      count_next = clear ? '0 : (count + CW'(wr_fire));
      start_ok   = idle_like && !clear && start && (count_next != '0);
      rd_idx     = (state == LOAD) ? (idx[AW-1:0] + AW'(1)) : '0;
   end

   instr_buffer #(
      .DEPTH (DEPTH),
      .WIDTH (WIDTH)
   ) u_buf (
      .clk     (clk),
      .Reset   (Reset),
      .clear   (idle_like && clear),
      .wr_en   (wr_fire),
      .wr_data (wr_data),
      .rd_idx  (rd_idx),
      .rd_data (rd_data),
      .count   (count)
   );

   always_ff @(posedge clk) begin
      if (Reset) begin
         state            <= IDLE;
         idx              <= '0;
         run_cnt          <= '0;
         LoadInstructions <= 1'b0;
         Instruction      <= '0;
         cpu_reset        <= 1'b1;
         busy             <= 1'b0;
         done             <= 1'b0;
         wr_ready         <= 1'b1;
      end else begin
         case (state)
            IDLE, DONE: begin
               cpu_reset        <= 1'b1;
               LoadInstructions <= 1'b0;
               Instruction      <= '0;
               if (clear) begin
                  state    <= IDLE;
                  done     <= 1'b0;
                  wr_ready <= 1'b1;
               end else if (start_ok) begin
                  state            <= LOAD;
                  idx              <= '0;
                  done             <= 1'b0;
                  busy             <= 1'b1;
                  wr_ready         <= 1'b0;
                  cpu_reset        <= 1'b0;
                  LoadInstructions <= 1'b1;
                  // A word written into an empty buffer this edge is not yet readable.
                  Instruction      <= (wr_fire && count == '0) ? wr_data : rd_data;
               end else begin
                  wr_ready <= (count_next < DEPTH_C);
               end
            end
            LOAD: begin
               if (idx + CW'(1) == count) begin
                  state            <= CPURST;
                  LoadInstructions <= 1'b0;
                  Instruction      <= '0;
                  cpu_reset        <= 1'b1;
               end else begin
                  idx         <= idx + CW'(1);
                  Instruction <= rd_data;
               end
            end
            CPURST: begin
               state     <= RUN;
               cpu_reset <= 1'b0;
               run_cnt   <= RW'(RUN_CYCLES);
            end
            RUN: begin
               if (run_cnt == RW'(1)) begin
                  state     <= DONE;
                  done      <= 1'b1;
                  busy      <= 1'b0;
                  cpu_reset <= 1'b1;
                  wr_ready  <= (count < DEPTH_C);
               end else begin
                  run_cnt <= run_cnt - RW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign dbg_state = state;

endmodule

// File: tb/tb_instr_load_sequencer.sv
// Self-checking bench for instr_load_sequencer: a cycle-schedule model checked every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_instr_load_sequencer;

   localparam int DEPTH      = 16;
   localparam int WIDTH      = 32;
   localparam int RUN_CYCLES = 10;
   localparam int CW         = $clog2(DEPTH) + 1;

   logic             clk;
   logic             Reset;
   logic             wr_valid;
   logic [WIDTH-1:0] wr_data;
   logic             wr_ready;
   logic             start;
   logic             clear;
   logic             LoadInstructions;
   logic [WIDTH-1:0] Instruction;
   logic             cpu_reset;
   logic             busy;
   logic             done;
   logic [CW-1:0]    count;
   logic [2:0]       dbg_state;

   instr_load_sequencer #(
      .DEPTH      (DEPTH),
      .WIDTH      (WIDTH),
      .RUN_CYCLES (RUN_CYCLES)
   ) dut (
      .clk              (clk),
      .Reset            (Reset),
      .wr_valid         (wr_valid),
      .wr_data          (wr_data),
      .wr_ready         (wr_ready),
      .start            (start),
      .clear            (clear),
      .LoadInstructions (LoadInstructions),
      .Instruction      (Instruction),
      .cpu_reset        (cpu_reset),
      .busy             (busy),
      .done             (done),
      .count            (count),
      .dbg_state        (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;
   bit chk_en      = 1'b0;

   function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   // Model: buffer contents plus a queue of per-cycle outputs for the running sequence.
   typedef struct {
      logic             lo;
      logic [WIDTH-1:0] instr;
      logic             rst;
   } step_t;

   logic [WIDTH-1:0] exp_q[$];
   step_t            sched[$];
   logic             m_done = 1'b0;

   always @(posedge clk) begin
      step_t s;
      if (Reset) begin
         exp_q.delete();
         sched.delete();
         m_done = 1'b0;
      end else if (sched.size() > 0) begin
         s = sched.pop_front();
         if (sched.size() == 0) m_done = 1'b1;
      end else if (clear) begin
         exp_q.delete();
         m_done = 1'b0;
      end else begin
         if (wr_valid && exp_q.size() < DEPTH) exp_q.push_back(wr_data);
         if (start && exp_q.size() > 0) begin
            foreach (exp_q[i]) sched.push_back('{lo: 1'b1, instr: exp_q[i], rst: 1'b0});
            sched.push_back('{lo: 1'b0, instr: '0, rst: 1'b1});
            for (int r = 0; r < RUN_CYCLES; r++) sched.push_back('{lo: 1'b0, instr: '0, rst: 1'b0});
            m_done = 1'b0;
         end
      end
   end

   // scoreboard compare, every cycle away from the active edge
   always @(negedge clk) begin
      if (chk_en) begin
         if (sched.size() > 0) begin
            chk("LoadInstructions", LoadInstructions, sched[0].lo);
            chk("Instruction", Instruction, sched[0].instr);
            chk("cpu_reset", cpu_reset, sched[0].rst);
            chk("busy", busy, 1'b1);
            chk("done", done, 1'b0);
            chk("wr_ready", wr_ready, 1'b0);
         end else begin
            chk("LoadInstructions", LoadInstructions, 1'b0);
            chk("Instruction", Instruction, '0);
            chk("cpu_reset", cpu_reset, 1'b1);
            chk("busy", busy, 1'b0);
            chk("done", done, m_done);
            chk("wr_ready", wr_ready, exp_q.size() < DEPTH);
         end
         chk("count", count, exp_q.size());
      end
   end

   // driver tasks
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic write_word(input logic [WIDTH-1:0] d);
      wr_valid = 1'b1;
      wr_data  = d;
      cyc();
      wr_valid = 1'b0;
   endtask

   task automatic start_pulse();
      start = 1'b1;
      cyc();
      start = 1'b0;
   endtask

   logic [WIDTH-1:0] got_q[$];
   int               lat;
   int               rst_pulses;

   // Called right after the start edge; records streamed words until done.
   task automatic capture();
      got_q.delete();
      lat        = -1;
      rst_pulses = 0;
      for (int i = 0; i < 60; i++) begin
         if (LoadInstructions) got_q.push_back(Instruction);
         if (cpu_reset && busy) rst_pulses++;
         if (done) begin
            lat = i;
            break;
         end
         cyc();
      end
   endtask

   initial begin
      Reset    = 1'b1;
      wr_valid = 1'b0;
      wr_data  = '0;
      start    = 1'b0;
      clear    = 1'b0;
      cyc();
      cyc();
      chk_en = 1'b1;
      chk("reset_LoadInstructions", LoadInstructions, 1'b0);
      chk("reset_cpu_reset", cpu_reset, 1'b1);
      chk("reset_wr_ready", wr_ready, 1'b1);
      chk("reset_count", count, 0);
      chk("reset_done", done, 1'b0);
      Reset = 1'b0;
      cyc();

      // basic three-word program
      write_word(32'h200101A7);
      write_word(32'h20020018);
      write_word(32'h200301B4);
      chk("t1_count", count, 3);
      start_pulse();
      chk("t1_load_entry", LoadInstructions, 1'b1);
      capture();
      chk("t1_words", got_q.size(), 3);
      chk("t1_w0", got_q[0], 32'h200101A7);
      chk("t1_w1", got_q[1], 32'h20020018);
      chk("t1_w2", got_q[2], 32'h200301B4);
      chk("t1_cpurst_pulses", rst_pulses, 1);
      chk("t1_latency", lat, 3 + 1 + RUN_CYCLES);

      // done holds, replay, then clear
      cyc();
      chk("t5_done_held", done, 1'b1);
      start_pulse();
      capture();
      chk("t5_words", got_q.size(), 3);
      chk("t5_w0", got_q[0], 32'h200101A7);
      chk("t5_w2", got_q[2], 32'h200301B4);
      chk("t5_latency", lat, 3 + 1 + RUN_CYCLES);
      clear = 1'b1;
      cyc();
      clear = 1'b0;
      chk("t5_clear_count", count, 0);
      chk("t5_clear_done", done, 1'b0);

      // start on an empty buffer is ignored
      start_pulse();
      cyc();
      chk("t3_busy", busy, 1'b0);
      chk("t3_load", LoadInstructions, 1'b0);

      // overfill
      for (int i = 0; i < 17; i++) write_word($urandom);
      chk("t2_count", count, 16);
      chk("t2_wr_ready", wr_ready, 1'b0);
      clear = 1'b1;
      cyc();
      clear = 1'b0;

      // write and start together
      write_word(32'h20040001);
      write_word(32'h20050002);
      wr_valid = 1'b1;
      wr_data  = 32'h8C040000;
      start    = 1'b1;
      cyc();
      wr_valid = 1'b0;
      start    = 1'b0;
      capture();
      chk("t6_words", got_q.size(), 3);
      chk("t6_w0", got_q[0], 32'h20040001);
      chk("t6_last", got_q[2], 32'h8C040000);
      chk("t6_latency", lat, 3 + 1 + RUN_CYCLES);

      // reset in the middle of LOAD
      clear = 1'b1;
      cyc();
      clear = 1'b0;
      write_word(32'h00221820);
      write_word(32'hAC030004);
      write_word(32'h00642022);
      start_pulse();
      cyc();
      chk("t4_second_word", Instruction, 32'hAC030004);
      Reset = 1'b1;
      cyc();
      Reset = 1'b0;
      chk("t4_load", LoadInstructions, 1'b0);
      chk("t4_count", count, 0);
      chk("t4_cpu_reset", cpu_reset, 1'b1);
      chk("t4_busy", busy, 1'b0);
      chk("t4_done", done, 1'b0);

      // randomized traffic against the model
      for (int i = 0; i < 2000; i++) begin
         wr_valid = 1'($urandom_range(0, 1));
         wr_data  = $urandom;
         start    = ($urandom_range(0, 15) == 0);
         clear    = ($urandom_range(0, 40) == 0);
         Reset    = ($urandom_range(0, 300) == 0);
         cyc();
      end
      wr_valid = 1'b0;
      start    = 1'b0;
      clear    = 1'b0;
      Reset    = 1'b0;
      cyc();
      cyc();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
